// File: rtl/mmio_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mmio_responder_pkg                                                    |
// | Shared register indices, control-bit positions and the default        |
// | window base for the memory-mapped I/O responder.                      |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
package mmio_responder_pkg;

  // ADDR[6:3] value that selects the I/O window (words 120-127).
  localparam logic [3:0] BASE_DEFAULT = 4'b1111;

  // Register index within the window, taken from ADDR[2:0].
  typedef enum logic [2:0] {
    REG_SW     = 3'd0,
    REG_BTN    = 3'd1,
    REG_SEG    = 3'd2,
    REG_TCTRL  = 3'd3,
    REG_TLOAD  = 3'd4,
    REG_TCOUNT = 3'd5,
    REG_TSTAT  = 3'd6,
    REG_LED    = 3'd7
  } reg_idx_e;

  // Bit positions inside TCTRL and TSTAT.
  localparam int TCTRL_EN      = 0;
  localparam int TCTRL_AUTO    = 1;
  localparam int TSTAT_EXPIRED = 0;

endpackage
`default_nettype wire

// File: rtl/mmio_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mmio_responder_if                                                     |
// | CPU data-bus control signals shared by the load/store initiator and   |
// | the peripheral responders.                                            |
// |   CS   : chip select                                                  |
// |   WE   : write enable (1 = store, 0 = load)                           |
// |   ADDR : 7-bit word address                                           |
// | The 32-bit Mem_Bus data lines are bidirectional and resolved at the   |
// | top level, so they travel as a plain inout next to this interface.    |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
interface mmio_responder_if;
  logic       CS;
  logic       WE;
  logic [6:0] ADDR;

  modport master (output CS, output WE, output ADDR);
  modport slave  (input  CS, input  WE, input  ADDR);
endinterface
`default_nettype wire

// File: rtl/mmio_responder_io_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mmio_responder_io_timer                                               |
// | Prescaler plus 32-bit down-counter with optional auto-reload.         |
// |   CLK, RST   : clock, synchronous active-high reset                   |
// |   en         : run enable; prescaler held at 0 while low              |
// |   auto       : reload from TLOAD at expiry instead of stopping        |
// |   load       : write strobe for TLOAD (also loads count)              |
// |   load_data  : value written with load                                |
// |   clear      : clear the expired flag                                 |
// |   tload      : reload register                                        |
// |   count      : current count                                          |
// |   expired    : sticky expiry flag                                     |
// |   expire_evt : one-cycle pulse on the tick that found count at zero   |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module mmio_responder_io_timer #(
  parameter int unsigned PRESCALE = 100000
) (
  input  wire logic        CLK,
  input  wire logic        RST,
  input  wire logic        en,
  input  wire logic        auto,
  input  wire logic        load,
  input  wire logic [31:0] load_data,
  input  wire logic        clear,
  output logic      [31:0] tload,
  output logic      [31:0] count,
  output logic             expired,
  output logic             expire_evt
);

  logic [31:0] r_pre;
  logic        w_tick;
  logic        w_zero;

  assign w_tick     = en & (r_pre == 32'(PRESCALE - 1));
  assign w_zero     = (count == 32'd0);
  assign expire_evt = w_tick & w_zero;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pre   <= '0;
      tload   <= '0;
      count   <= '0;
      expired <= 1'b0;
    end else begin
      if (!en || w_tick) r_pre <= '0;
      else               r_pre <= r_pre + 32'd1;

      if (load) tload <= load_data;

      // A TLOAD write beats the tick; at zero without auto the count
      // simply stays at zero while the top drops en.
      if (load)                count <= load_data;
      else if (w_tick) begin
        if (!w_zero)           count <= count - 32'd1;
        else if (auto)         count <= tload;
      end

      // Expiry wins over a same-cycle clear.
      if (expire_evt)          expired <= 1'b1;
      else if (clear)          expired <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mmio_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mmio_responder                                                        |
// | Memory-mapped I/O responder decoding an 8-word window on the CPU      |
// | data bus: switches, sticky button events, seven-seg value, LEDs and   |
// | a down-counting timer.                                                |
// |   CLK, RST  : clock, synchronous active-high reset                    |
// |   bus       : CS / WE / ADDR (slave modport)                          |
// |   Mem_Bus   : 32-bit shared data bus, driven only on a window read    |
// |   sw        : raw switches (2-flop synchronised)                      |
// |   btn_l/r   : debounced buttons                                       |
// |   io_hit    : combinational window decode, used to gate the RAM CS    |
// |   seg_value : SEG register                                            |
// |   led       : LED register                                            |
// |   timer_irq : registered copy of the timer expired flag               |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module mmio_responder
  import mmio_responder_pkg::*;
#(
  parameter logic [3:0]  BASE     = BASE_DEFAULT,
  parameter int unsigned PRESCALE = 100000
) (
  input  wire logic        CLK,
  input  wire logic        RST,
  mmio_responder_if.slave  bus,
  inout  wire       [31:0] Mem_Bus,
  input  wire logic [2:0]  sw,
  input  wire logic        btn_l,
  input  wire logic        btn_r,
  output logic             io_hit,
  output logic      [15:0] seg_value,
  output logic      [7:0]  led,
  output logic             timer_irq
);

  reg_idx_e    w_idx;
  logic        w_wr, w_rd_act;
  logic [31:0] w_rdata;

  logic [2:0]  r_sw_s1, r_sw_s2;
  logic        r_btn_l_d, r_btn_r_d;
  logic [1:0]  r_ev;       // {evL, evR}
  logic [1:0]  r_snap;     // events seen when the current BTN read began
  logic        r_rd_act_d;
  logic        r_rd_btn_d; // previous cycle was a read of BTN
  logic        r_en, r_auto;

  logic [1:0]  w_ev_rise, w_ev_clr;
  logic        w_btn_rd_start, w_btn_rd_end;

  logic [31:0] w_tload, w_count;
  logic        w_expired, w_expire_evt;

  assign w_idx    = reg_idx_e'(bus.ADDR[2:0]);
  assign io_hit   = bus.CS & (bus.ADDR[6:3] == BASE);
  assign w_wr     = io_hit & bus.WE;
  assign w_rd_act = io_hit & ~bus.WE;

  // Held off during reset so the bus stays released until a real read.
  assign Mem_Bus = (w_rd_act & ~RST) ? w_rdata : 32'bz;

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      REG_SW:     w_rdata = {29'b0, r_sw_s2};
      REG_BTN:    w_rdata = {30'b0, r_ev};
      REG_SEG:    w_rdata = {16'b0, seg_value};
      REG_TCTRL:  w_rdata = {30'b0, r_auto, r_en};
      REG_TLOAD:  w_rdata = w_tload;
      REG_TCOUNT: w_rdata = w_count;
      REG_TSTAT:  w_rdata = {31'b0, w_expired};
      REG_LED:    w_rdata = {24'b0, led};
      default:    w_rdata = '0;
    endcase
  end

  // Clear-on-read: only events captured when the read began are cleared
  // when it ends, so events arriving mid-read stay pending. A fresh edge
  // in the clearing cycle wins over the clear.
  assign w_ev_rise      = {btn_l & ~r_btn_l_d, btn_r & ~r_btn_r_d};
  assign w_btn_rd_start = w_rd_act & ~r_rd_act_d & (w_idx == REG_BTN);
  assign w_btn_rd_end   = r_rd_act_d & ~w_rd_act & r_rd_btn_d;
  assign w_ev_clr       = w_btn_rd_end ? r_snap : 2'b00;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sw_s1    <= '0;
      r_sw_s2    <= '0;
      r_btn_l_d  <= 1'b0;
      r_btn_r_d  <= 1'b0;
      r_ev       <= '0;
      r_snap     <= '0;
      r_rd_act_d <= 1'b0;
      r_rd_btn_d <= 1'b0;
      r_en       <= 1'b0;
      r_auto     <= 1'b0;
      seg_value  <= '0;
      led        <= '0;
      timer_irq  <= 1'b0;
    end else begin
      r_sw_s1    <= sw;
      r_sw_s2    <= r_sw_s1;
      r_btn_l_d  <= btn_l;
      r_btn_r_d  <= btn_r;
      r_ev       <= (r_ev & ~w_ev_clr) | w_ev_rise;
      if (w_btn_rd_start) r_snap <= r_ev;
      r_rd_act_d <= w_rd_act;
      r_rd_btn_d <= w_rd_act & (w_idx == REG_BTN);
      timer_irq  <= w_expired;

      // One-shot expiry stops the timer; a TCTRL write below overrides.
      if (w_expire_evt && !r_auto) r_en <= 1'b0;

      if (w_wr) begin
        case (w_idx)
          REG_SEG:   seg_value <= Mem_Bus[15:0];
          REG_TCTRL: begin
            r_en   <= Mem_Bus[TCTRL_EN];
            r_auto <= Mem_Bus[TCTRL_AUTO];
          end
          REG_LED:   led <= Mem_Bus[7:0];
          default:   ;
        endcase
      end
    end
  end

  mmio_responder_io_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .CLK        (CLK),
    .RST        (RST),
    .en         (r_en),
    .auto       (r_auto),
    .load       (w_wr & (w_idx == REG_TLOAD)),
    .load_data  (Mem_Bus),
    .clear      (w_wr & (w_idx == REG_TSTAT) & Mem_Bus[TSTAT_EXPIRED]),
    .tload      (w_tload),
    .count      (w_count),
    .expired    (w_expired),
    .expire_evt (w_expire_evt)
  );

endmodule
`default_nettype wire

// File: tb/tb_mmio_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mmio_responder                                                     |
// | Self-checking bench for mmio_responder. A small RAM stand-in drives   |
// | Mem_Bus whenever the responder must not, so an undriven responder is  |
// | seen as the RAM value on the bus.                                     |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module tb_mmio_responder;
  import mmio_responder_pkg::*;

  localparam int unsigned PS = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  wire  [31:0] Mem_Bus;
  logic [2:0]  sw = 3'd0;
  logic        btn_l = 1'b0, btn_r = 1'b0;
  logic        io_hit, timer_irq;
  logic [15:0] seg_value;
  logic [7:0]  led;

  logic        drv_en = 1'b0;
  logic [31:0] drv_val = '0;
  logic [31:0] ram_val = 32'h0BAD_F00D;
  logic        ram_en;
  logic [2:0]  sw_cur = 3'd0;

  int vectors = 0;
  int miscompares = 0;

  mmio_responder_if bus ();

  mmio_responder #(.BASE(4'hF), .PRESCALE(PS)) dut (
    .CLK(CLK), .RST(RST), .bus(bus), .Mem_Bus(Mem_Bus), .sw(sw),
    .btn_l(btn_l), .btn_r(btn_r), .io_hit(io_hit), .seg_value(seg_value),
    .led(led), .timer_irq(timer_irq)
  );

  // RAM stand-in: drives unless the bench is storing or a window load is
  // in progress outside reset.
  assign ram_en  = ~drv_en & (~(bus.CS & ~bus.WE & (bus.ADDR[6:3] == 4'hF)) | RST);
  assign Mem_Bus = drv_en ? drv_val : (ram_en ? ram_val : 32'bz);

  always #5 CLK = ~CLK;

  task automatic bus_idle();
    bus.CS = 1'b0; bus.WE = 1'b0; bus.ADDR = 7'd0; drv_en = 1'b0;
  endtask

  task automatic bus_write(input logic [2:0] idx, input logic [31:0] d);
    @(negedge CLK);
    bus.CS = 1'b1; bus.WE = 1'b1; bus.ADDR = {4'hF, idx}; drv_val = d; drv_en = 1'b1;
    @(negedge CLK);
    bus_idle();
  endtask

  task automatic bus_read(input logic [2:0] idx, output logic [31:0] d);
    @(negedge CLK);
    bus.CS = 1'b1; bus.WE = 1'b0; bus.ADDR = {4'hF, idx};
    #1 d = Mem_Bus;
    @(negedge CLK);
    bus_idle();
  endtask

  task automatic pulse_btn(input logic [1:0] b);
    @(negedge CLK); btn_l = b[1]; btn_r = b[0];
    @(negedge CLK); btn_l = 1'b0; btn_r = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    vectors++; if (seg_value !== 16'h0) begin miscompares++; $display("FAIL rst_seg: got %h expected 0", seg_value); end
    vectors++; if (led !== 8'h0) begin miscompares++; $display("FAIL rst_led: got %h expected 0", led); end
    vectors++; if (timer_irq !== 1'b0) begin miscompares++; $display("FAIL rst_irq: got %b expected 0", timer_irq); end
    vectors++; if (Mem_Bus !== ram_val) begin miscompares++; $display("FAIL rst_bus_released: got %h expected %h", Mem_Bus, ram_val); end
    RST = 1'b0;
    bus_read(REG_TCOUNT, rd);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL rst_tcount: got %h expected 0", rd); end
    bus_read(REG_TSTAT, rd);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL rst_tstat: got %h expected 0", rd); end
    bus_read(REG_BTN, rd);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL rst_btn: got %h expected 0", rd); end
  endtask

  task automatic test_decode();
    logic [6:0] a;
    for (int i = 0; i < 6; i++) begin
      a = 7'($urandom_range(0, 119));
      @(negedge CLK);
      ram_val = $urandom;
      bus.CS = 1'b1; bus.WE = 1'b0; bus.ADDR = a;
      #1;
      vectors++; if (io_hit !== 1'b0) begin miscompares++; $display("FAIL decode_miss_hit: addr %0d got %b expected 0", a, io_hit); end
      vectors++; if (Mem_Bus !== ram_val) begin miscompares++; $display("FAIL decode_miss_bus: addr %0d got %h expected %h", a, Mem_Bus, ram_val); end
      @(negedge CLK);
      bus.CS = 1'b0; bus.ADDR = 7'(120 + i);
      #1;
      vectors++; if (io_hit !== 1'b0 || Mem_Bus !== ram_val) begin miscompares++; $display("FAIL decode_cs_low: hit %b bus %h expected 0 / %h", io_hit, Mem_Bus, ram_val); end
      bus.CS = 1'b1;
      #1;
      vectors++; if (io_hit !== 1'b1) begin miscompares++; $display("FAIL decode_window_hit: addr %0d got %b expected 1", 120 + i, io_hit); end
    end
    @(negedge CLK); bus_idle();
  endtask

  task automatic test_sw_sync();
    logic [2:0] v;
    for (int i = 0; i < 4; i++) begin
      v = 3'($urandom_range(0, 7));
      @(negedge CLK);
      sw = v; bus.CS = 1'b1; bus.WE = 1'b0; bus.ADDR = {4'hF, REG_SW};
      @(negedge CLK); #1;
      vectors++; if (Mem_Bus !== {29'b0, sw_cur}) begin miscompares++; $display("FAIL sw_sync_1clk: got %h expected %h", Mem_Bus, {29'b0, sw_cur}); end
      @(negedge CLK); #1;
      vectors++; if (Mem_Bus !== {29'b0, v}) begin miscompares++; $display("FAIL sw_sync_2clk: got %h expected %h", Mem_Bus, {29'b0, v}); end
      sw_cur = v;
    end
    @(negedge CLK); bus_idle();
  endtask

  task automatic test_regs();
    logic [31:0] s, l, t, a, rd;
    for (int i = 0; i < 5; i++) begin
      s = $urandom; l = $urandom; t = $urandom; a = $urandom;
      bus_write(REG_SEG, s);
      vectors++; if (seg_value !== s[15:0]) begin miscompares++; $display("FAIL seg_out: got %h expected %h", seg_value, s[15:0]); end
      bus_read(REG_SEG, rd);
      vectors++; if (rd !== {16'b0, s[15:0]}) begin miscompares++; $display("FAIL seg_read: got %h expected %h", rd, {16'b0, s[15:0]}); end
      bus_write(REG_LED, l);
      vectors++; if (led !== l[7:0]) begin miscompares++; $display("FAIL led_out: got %h expected %h", led, l[7:0]); end
      bus_read(REG_LED, rd);
      vectors++; if (rd !== {24'b0, l[7:0]}) begin miscompares++; $display("FAIL led_read: got %h expected %h", rd, {24'b0, l[7:0]}); end
      bus_write(REG_TLOAD, t);
      bus_read(REG_TLOAD, rd);
      vectors++; if (rd !== t) begin miscompares++; $display("FAIL tload_read: got %h expected %h", rd, t); end
      bus_read(REG_TCOUNT, rd);
      vectors++; if (rd !== t) begin miscompares++; $display("FAIL tload_sets_count: got %h expected %h", rd, t); end
      bus_write(REG_TCOUNT, ~t);
      bus_read(REG_TCOUNT, rd);
      vectors++; if (rd !== t) begin miscompares++; $display("FAIL tcount_readonly: got %h expected %h", rd, t); end
      bus_write(REG_TCTRL, a & 32'hFFFF_FFFE);
      bus_read(REG_TCTRL, rd);
      vectors++; if (rd !== (a & 32'h2)) begin miscompares++; $display("FAIL tctrl_read: got %h expected %h", rd, a & 32'h2); end
      bus_write(REG_SW, $urandom);
      bus_read(REG_SW, rd);
      vectors++; if (rd !== {29'b0, sw_cur}) begin miscompares++; $display("FAIL sw_readonly: got %h expected %h", rd, {29'b0, sw_cur}); end
    end
    bus_write(REG_TCTRL, 32'h0);
  endtask

  // Pending events modelled as a set: a read clears exactly what was
  // pending when it began; anything arriving later survives.
  task automatic test_btn();
    logic [1:0]  pending, snap, pre, pb, eb;
    logic [31:0] rd;
    int len, pc;
    pending = 2'b00;
    for (int i = 0; i < 8; i++) begin
      pre = 2'($urandom_range(1, 3));
      pulse_btn(pre);
      pending = pending | pre;
      snap = pending;
      len = $urandom_range(3, 6);
      pc  = $urandom_range(1, len - 2);
      pb  = 2'($urandom_range(0, 3));
      eb  = 2'($urandom_range(0, 3));
      for (int c = 0; c < len; c++) begin
        @(negedge CLK);
        if (c == pc + 1) pending = pending | pb;
        bus.CS = 1'b1; bus.WE = 1'b0; bus.ADDR = {4'hF, REG_BTN};
        btn_l = (c == pc) ? pb[1] : 1'b0;
        btn_r = (c == pc) ? pb[0] : 1'b0;
        #1;
        vectors++; if (Mem_Bus !== {30'b0, pending}) begin miscompares++; $display("FAIL btn_held_read: cycle %0d got %h expected %h", c, Mem_Bus, {30'b0, pending}); end
      end
      @(negedge CLK);
      bus_idle(); btn_l = eb[1]; btn_r = eb[0];
      @(negedge CLK);
      btn_l = 1'b0; btn_r = 1'b0;
      pending = (pending & ~snap) | eb;
      bus_read(REG_BTN, rd);
      vectors++; if (rd !== {30'b0, pending}) begin miscompares++; $display("FAIL btn_after_clear: got %h expected %h", rd, {30'b0, pending}); end
      pending = 2'b00;
    end
    @(negedge CLK);
  endtask

  task automatic test_timer_oneshot();
    logic [31:0] rd, exp_cnt;
    int L, tk;
    logic exp_x, exp_irq;
    bus_write(REG_TSTAT, 32'h1);
    L = $urandom_range(1, 5);
    bus_write(REG_TLOAD, 32'(L));
    bus_write(REG_TCTRL, 32'h1);
    for (int n = 0; n <= 4 * (L + 1) + 6; n++) begin
      tk = n / 4;
      exp_cnt = 32'(L - ((tk < L) ? tk : L));
      exp_x   = (tk >= L + 1);
      exp_irq = (n >= 1) && ((n - 1) / 4 >= L + 1);
      bus.CS = 1'b1; bus.WE = 1'b0;
      bus.ADDR = {4'hF, (n % 2 == 1) ? REG_TSTAT : REG_TCOUNT};
      #1;
      if (n % 2 == 1) begin
        vectors++; if (Mem_Bus !== {31'b0, exp_x}) begin miscompares++; $display("FAIL oneshot_expired: n %0d got %h expected %h", n, Mem_Bus, {31'b0, exp_x}); end
      end else begin
        vectors++; if (Mem_Bus !== exp_cnt) begin miscompares++; $display("FAIL oneshot_count: n %0d got %h expected %h", n, Mem_Bus, exp_cnt); end
      end
      vectors++; if (timer_irq !== exp_irq) begin miscompares++; $display("FAIL oneshot_irq: n %0d got %b expected %b", n, timer_irq, exp_irq); end
      @(negedge CLK);
    end
    bus_idle();
    bus_read(REG_TCTRL, rd);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL oneshot_en_cleared: got %h expected 0", rd); end
  endtask

  task automatic test_timer_auto();
    logic [31:0] rd, exp_cnt;
    int L, tk;
    logic exp_x, exp_irq;
    bus_write(REG_TSTAT, 32'h1);
    L = $urandom_range(1, 4);
    bus_write(REG_TLOAD, 32'(L));
    bus_write(REG_TCTRL, 32'h3);
    for (int n = 0; n <= 8 * (L + 1) + 3; n++) begin
      tk = n / 4;
      exp_cnt = 32'(L - (tk % (L + 1)));
      exp_x   = (tk >= L + 1);
      exp_irq = (n >= 1) && ((n - 1) / 4 >= L + 1);
      bus.CS = 1'b1; bus.WE = 1'b0;
      bus.ADDR = {4'hF, (n % 2 == 1) ? REG_TSTAT : REG_TCOUNT};
      #1;
      if (n % 2 == 1) begin
        vectors++; if (Mem_Bus !== {31'b0, exp_x}) begin miscompares++; $display("FAIL auto_expired: n %0d got %h expected %h", n, Mem_Bus, {31'b0, exp_x}); end
      end else begin
        vectors++; if (Mem_Bus !== exp_cnt) begin miscompares++; $display("FAIL auto_count: n %0d got %h expected %h", n, Mem_Bus, exp_cnt); end
      end
      vectors++; if (timer_irq !== exp_irq) begin miscompares++; $display("FAIL auto_irq: n %0d got %b expected %b", n, timer_irq, exp_irq); end
      @(negedge CLK);
    end
    bus_idle();
    bus_write(REG_TCTRL, 32'h0);
    bus_write(REG_TSTAT, 32'h0);
    bus_read(REG_TSTAT, rd);
    vectors++; if (rd !== 32'h1) begin miscompares++; $display("FAIL tstat_write0_noop: got %h expected 1", rd); end
    bus_write(REG_TSTAT, 32'h1);
    bus_read(REG_TSTAT, rd);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL tstat_write1_clears: got %h expected 0", rd); end
    vectors++; if (timer_irq !== 1'b0) begin miscompares++; $display("FAIL irq_follows_clear: got %b expected 0", timer_irq); end
  endtask

  // TLOAD written on the very cycle of a tick must replace the count.
  task automatic test_load_priority();
    logic [31:0] v;
    bus_write(REG_TLOAD, 32'd10);
    bus_write(REG_TCTRL, 32'h1);
    @(negedge CLK);
    @(negedge CLK);
    v = 32'($urandom_range(20, 200));
    bus_write(REG_TLOAD, v);
    bus.CS = 1'b1; bus.WE = 1'b0; bus.ADDR = {4'hF, REG_TCOUNT};
    #1;
    vectors++; if (Mem_Bus !== v) begin miscompares++; $display("FAIL load_beats_tick: got %h expected %h", Mem_Bus, v); end
    repeat (4) @(negedge CLK);
    #1;
    vectors++; if (Mem_Bus !== v - 32'd1) begin miscompares++; $display("FAIL count_after_load: got %h expected %h", Mem_Bus, v - 32'd1); end
    bus_idle();
    bus_write(REG_TCTRL, 32'h0);
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] rd;
    pulse_btn(2'b10);
    bus_write(REG_SEG, 32'h0000_BEEF);
    bus_write(REG_LED, 32'h0000_005A);
    @(negedge CLK);
    bus.CS = 1'b1; bus.WE = 1'b0; bus.ADDR = {4'hF, REG_BTN};
    #1;
    vectors++; if (Mem_Bus !== 32'h2) begin miscompares++; $display("FAIL pre_reset_btn: got %h expected 2", Mem_Bus); end
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); #1;
    vectors++; if (seg_value !== 16'h0 || led !== 8'h0 || timer_irq !== 1'b0) begin miscompares++; $display("FAIL midread_rst_outputs: seg %h led %h irq %b expected 0", seg_value, led, timer_irq); end
    vectors++; if (Mem_Bus !== ram_val) begin miscompares++; $display("FAIL midread_rst_bus: got %h expected %h", Mem_Bus, ram_val); end
    @(negedge CLK); RST = 1'b0;
    #1;
    vectors++; if (Mem_Bus !== 32'h0) begin miscompares++; $display("FAIL post_reset_btn: got %h expected 0", Mem_Bus); end
    @(negedge CLK); btn_l = 1'b1;
    @(negedge CLK); btn_l = 1'b0;
    @(negedge CLK); bus_idle();
    @(negedge CLK);
    bus_read(REG_BTN, rd);
    vectors++; if (rd !== 32'h2) begin miscompares++; $display("FAIL no_spurious_clear: got %h expected 2", rd); end
    bus_read(REG_BTN, rd);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL clear_after_reread: got %h expected 0", rd); end
  endtask

  initial begin
    bus_idle();
    test_reset();
    test_decode();
    test_sw_sync();
    test_regs();
    test_btn();
    test_timer_oneshot();
    test_timer_auto();
    test_load_priority();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
Memory-mapped I/O responder on the CPU data bus (CS, WE, 7-bit ADDR, 32-bit bidirectional Mem_Bus), the peripheral-side counterpart to the CPU's load/store initiator. It decodes an 8-word window and exposes switches, debounced-button events, a seven-segment value register, LEDs and a down-counting timer. It is instanced beside the RAM in the top level. The top gates the RAM's CS with ~io_hit so that only one responder drives the bus.

Parameters:
BASE, 4'b1111, ADDR[6:3] value that selects this window (words 120-127).
PRESCALE, 100000, CLK cycles per timer tick; minimum 1.

Ports:
CLK  in  1  system clock (fast clock, same as RAM)
RST  in  1  synchronous, active-high reset
CS  in  1  bus chip select from CPU
WE  in  1  bus write enable from CPU
ADDR  in  7  word address
Mem_Bus  inout  32  shared data bus
sw  in  3  raw switches
btn_l  in  1  debounced left button
btn_r  in  1  debounced right button
io_hit  out  1  CS & (ADDR[6:3]==BASE); combinational
seg_value  out  16  value for the BCD/seven-seg path
led  out  8  LED register
timer_irq  out  1  copy of the timer expired flag

Behaviour:
- Decode: sel = io_hit. Register index is ADDR[2:0].
- Bus drive: Mem_Bus = (sel & ~WE) ? rdata : 32'bZ. rdata is a combinational mux of the registers listed below. With CS=0 or WE=1, Mem_Bus is never driven.
- Writes: level-sensitive. On every posedge CLK while sel & WE, write Mem_Bus into the register at the selected index. Writes to read-only registers are ignored.
- Register map:
  - 0 SW: {29'b0, sw_sync}, read-only. sw passes through a 2-flop synchroniser.
  - 1 BTN: {30'b0, evL, evR}, read-only. Sticky rising-edge events on btn_l and btn_r, with one-cycle edge detect.
  - 2 SEG: [15:0] read/write, drives seg_value. Upper bits read 0.
  - 3 TCTRL: bit0 en, bit1 auto; read/write. Other bits read 0.
  - 4 TLOAD: 32-bit read/write. Every write also sets count <= written value.
  - 5 TCOUNT: current count, read-only.
  - 6 TSTAT: bit0 expired. Writing 1 to bit0 clears it; writing 0 has no effect.
  - 7 LED: [7:0] read/write.
- BTN clear-on-read:
  - rd_act = sel & ~WE, registered once to rd_act_d.
  - At the rising edge of rd_act for index 1, snapshot {evL, evR} into snap.
  - At the falling edge of rd_act (rd_act_d & ~rd_act) where the read was index 1, clear only the bits set in snap.
  - An edge that arrives during the read stays pending.
  - Data returned during a held read is stable unless a new event sets a bit.
  - If an edge and a clear hit the same bit in the same cycle, set wins.
- Prescaler: counts 0..PRESCALE-1 while en=1 and emits a one-cycle tick at wrap. It holds at 0 while en=0.
- Timer, on tick:
  - If count==0: expired<=1. Then count<=TLOAD if auto=1, else en<=0.
  - Otherwise count<=count-1.
  - A TLOAD write in the same cycle as a tick takes priority over the decrement.
  - If expiry and a TSTAT clear occur in the same cycle, set wins.
- timer_irq = expired, registered.
- Reset values: seg_value=0, led=0, en=0, auto=0, TLOAD=0, count=0, expired=0, timer_irq=0, evL=0, evR=0, snap=0, prescaler=0, synchronisers=0, rd_act_d=0. Mem_Bus is Z during and after reset until a read.
- Reset mid-access: all state returns to reset values. A read still active after reset does not trigger the BTN clear, because rd_act_d=0.
- Latency:
  - Read data is valid combinationally in the same cycle as a select, so the CPU samples it at its next clock.
  - A written register shows the new value one CLK after the write.

Decomposition:
- Shared package: register index constants (REG_SW..REG_LED), TCTRL bit positions, BASE default.
- One sub-module, io_timer: prescaler plus down-counter, with ports tick-enable/load/auto/clear and outputs count/expired.
- Bus decode, register file and event logic stay in the top of this block.

Test Plan:
- Reset then read idx 5 (ADDR=125) -> Mem_Bus=0. CS=0 -> Mem_Bus=Z. Read at ADDR=10 -> io_hit=0, bus undriven.
- Write 0x1234 to idx 2, then 0xA5 to idx 7 -> seg_value=16'h1234, led=8'hA5. Read idx 2 -> 0x00001234.
- Pulse btn_l; read idx 1 for 5 cycles -> 0x2 throughout. After CS drops, a re-read -> 0. Pulse btn_r mid-read -> after the read ends, 0x1 remains.
- PRESCALE=4. Write TLOAD=3, TCTRL=1 -> count 3,2,1,0 every 4 cycles. On the next tick, expired=1, timer_irq=1 one cycle later, en=0, count holds 0.
- TCTRL=3, TLOAD=2 -> count sequence 2,1,0,2,1,0 and expired set. Write TSTAT=1 -> expired=0. Write TSTAT=0 -> no change.
- Assert RST mid-read of idx 1 with evL set -> all outputs at reset values, bus Z, no spurious clear once reset releases.
